// File: rtl/data_mem_responder.sv
// Memory-side responder for the data cache: single-word stores after a fixed
// latency, and line reads returned as a backpressured burst of BURST_LEN words.
module data_mem_responder #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int BURST_LEN      = 4,
    parameter int LATENCY        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_last,
    output logic                     wr_done
);

    localparam int WORD_AW = MEM_ADDR_WIDTH - 2;
    localparam int WORDS   = 1 << WORD_AW;
    localparam int LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [WORD_AW-1:0] LINE_MASK = WORD_AW'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]   LAT_LOAD  = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t                  state_q;
    logic [LAT_W-1:0]        lat_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    we_q;
    logic [WORD_AW-1:0]      idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_valid_q;
    logic                    rsp_last_q;
    logic                    wr_done_q;

    logic [DATA_WIDTH-1:0]   mem_q [WORDS];

    logic [WORD_AW-1:0]      line_base;
    logic [BEAT_W-1:0]       beat_inc;
    logic [WORD_AW-1:0]      next_idx;
    logic                    commit;
    logic                    unused_addr_bits;

    // Address bits above the decoded window alias; byte-offset bits are ignored.
    assign unused_addr_bits = ^{req_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH], req_addr[1:0]};

    assign line_base = idx_q & ~LINE_MASK;
    assign beat_inc  = beat_q + BEAT_W'(1);
    assign next_idx  = line_base + WORD_AW'(beat_inc);
    assign commit    = (state_q == WAIT) && (lat_q == '0) && we_q;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign wr_done   = wr_done_q;

    // Gated by !rst so a reset on the commit edge drops the pending store.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            beat_q      <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        idx_q   <= req_addr[MEM_ADDR_WIDTH-1:2];
                        wdata_q <= req_wdata;
                        lat_q   <= LAT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        if (we_q) begin
                            wr_done_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            rsp_data_q  <= mem_q[line_base];
                            beat_q      <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_last_q  <= (BEAT_LAST == '0);
                            state_q     <= BURST;
                        end
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                BURST: begin
                    if (rsp_ready) begin
                        if (rsp_last_q) begin
                            rsp_valid_q <= 1'b0;
                            rsp_last_q  <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            beat_q     <= beat_inc;
                            rsp_data_q <= mem_q[next_idx];
                            rsp_last_q <= (beat_inc == BEAT_LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
